// File: rtl/mem_access_initiator.sv
// Request-side controller for the 32x32 single-port memory: valid/ready command in, one response out per command.
// Optional transaction counters (Wr_Count/Rd_Count/Err_Count) are built when MEM_INIT_TXN_COUNT_EN is defined.
module mem_access_initiator #(
    parameter int Data_Width    = 32,
    parameter int Address_Width = 5,
    parameter int Timeout_Cyc   = 8
) (
    input  logic                     CLK,
    input  logic                     Rst_n,
    input  logic                     Req_Valid,
    output logic                     Req_Ready,
    input  logic                     Req_Write,
    input  logic [Address_Width-1:0] Req_Addr,
    input  logic [Data_Width-1:0]    Req_Wdata,
    output logic                     Rsp_Valid,
    input  logic                     Rsp_Ready,
    output logic                     Rsp_Write,
    output logic [Data_Width-1:0]    Rsp_Rdata,
    output logic                     Rsp_Err,
    output logic                     Mem_Wr_En,
    output logic                     Mem_Rd_En,
    output logic [Address_Width-1:0] Mem_Address,
    output logic [Data_Width-1:0]    Mem_Data_in,
    input  logic [Data_Width-1:0]    Mem_Data_out,
    input  logic                     Mem_Valid_out
`ifdef MEM_INIT_TXN_COUNT_EN
    ,
    output logic [15:0]              Wr_Count,
    output logic [15:0]              Rd_Count,
    output logic [15:0]              Err_Count
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        WAIT_RD = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(Timeout_Cyc - 1);

    state_t                   state_q, state_d;
    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     rsp_write_q, rsp_write_d;
    logic [Data_Width-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_err_q, rsp_err_d;
    logic                     mem_wr_en_q, mem_wr_en_d;
    logic                     mem_rd_en_q, mem_rd_en_d;
    logic [Address_Width-1:0] mem_address_q, mem_address_d;
    logic [Data_Width-1:0]    mem_data_in_q, mem_data_in_d;
    logic [7:0]               wd_cnt_q, wd_cnt_d;

    // Next-state and next-output logic; every output is the registered image of its _d value.
    always_comb begin
        state_d       = state_q;
        req_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        mem_wr_en_d   = 1'b0;
        mem_rd_en_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        wd_cnt_d      = wd_cnt_q;
        case (state_q)
            IDLE: begin
                // Ready is only honoured once its register is up, so nothing is taken in the cycle after reset.
                if (Req_Valid && req_ready_q) begin
                    mem_address_d = Req_Addr;
                    if (Req_Write) begin
                        state_d       = WRITE;
                        mem_data_in_d = Req_Wdata;
                        mem_wr_en_d   = 1'b1;
                    end else begin
                        state_d     = READ;
                        mem_rd_en_d = 1'b1;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            READ: begin
                state_d  = WAIT_RD;
                wd_cnt_d = 8'd0;
            end
            WAIT_RD: begin
                if (Mem_Valid_out) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = Mem_Data_out;
                    rsp_err_d   = 1'b0;
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (Rsp_Ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            wd_cnt_q      <= 8'd0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    assign Req_Ready   = req_ready_q;
    assign Rsp_Valid   = rsp_valid_q;
    assign Rsp_Write   = rsp_write_q;
    assign Rsp_Rdata   = rsp_rdata_q;
    assign Rsp_Err     = rsp_err_q;
    assign Mem_Wr_En   = mem_wr_en_q;
    assign Mem_Rd_En   = mem_rd_en_q;
    assign Mem_Address = mem_address_q;
    assign Mem_Data_in = mem_data_in_q;

`ifdef MEM_INIT_TXN_COUNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] err_count_q, err_count_d;

    // Per-category counters bump on the response handshake; a timeout counts as an error only.
    always_comb begin
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        err_count_d = err_count_q;
        if (state_q == RESP && rsp_valid_q && Rsp_Ready) begin
            if (rsp_err_q) begin
                err_count_d = sat_inc(err_count_q);
            end else if (rsp_write_q) begin
                wr_count_d = sat_inc(wr_count_q);
            end else begin
                rd_count_d = sat_inc(rd_count_q);
            end
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_count_q  <= 16'd0;
            rd_count_q  <= 16'd0;
            err_count_q <= 16'd0;
        end else begin
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign Wr_Count  = wr_count_q;
    assign Rd_Count  = rd_count_q;
    assign Err_Count = err_count_q;
`endif

endmodule

// File: tb/tb_mem_access_initiator.sv
// Self-checking bench for mem_access_initiator with a behavioural 32x32 memory that can be stubbed silent.
module tb_mem_access_initiator;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        CLK = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Req_Valid = 1'b0;
    logic        Req_Ready;
    logic        Req_Write = 1'b0;
    logic [4:0]  Req_Addr = 5'd0;
    logic [31:0] Req_Wdata = 32'd0;
    logic        Rsp_Valid;
    logic        Rsp_Ready = 1'b1;
    logic        Rsp_Write;
    logic [31:0] Rsp_Rdata;
    logic        Rsp_Err;
    logic        Mem_Wr_En;
    logic        Mem_Rd_En;
    logic [4:0]  Mem_Address;
    logic [31:0] Mem_Data_in;
    logic [31:0] Mem_Data_out;
    logic        Mem_Valid_out;
`ifdef MEM_INIT_TXN_COUNT_EN
    logic [15:0] Wr_Count, Rd_Count, Err_Count;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_wr = 0, exp_rd = 0, exp_err = 0;
    bit   stub = 1'b0;
    rsp_t exp_q[$];
    logic [31:0] mem [32];

    mem_access_initiator #(.Data_Width(32), .Address_Width(5), .Timeout_Cyc(8)) dut (
        .CLK(CLK), .Rst_n(Rst_n),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
        .Req_Addr(Req_Addr), .Req_Wdata(Req_Wdata),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Write(Rsp_Write),
        .Rsp_Rdata(Rsp_Rdata), .Rsp_Err(Rsp_Err),
        .Mem_Wr_En(Mem_Wr_En), .Mem_Rd_En(Mem_Rd_En), .Mem_Address(Mem_Address),
        .Mem_Data_in(Mem_Data_in), .Mem_Data_out(Mem_Data_out), .Mem_Valid_out(Mem_Valid_out)
`ifdef MEM_INIT_TXN_COUNT_EN
        , .Wr_Count(Wr_Count), .Rd_Count(Rd_Count), .Err_Count(Err_Count)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory model: registered read, Valid_out one cycle after Rd_En, cleared by reset.
    always @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
            Mem_Data_out  <= 32'd0;
            Mem_Valid_out <= 1'b0;
        end else begin
            Mem_Valid_out <= 1'b0;
            if (Mem_Wr_En) mem[Mem_Address] <= Mem_Data_in;
            if (Mem_Rd_En && !stub) begin
                Mem_Data_out  <= mem[Mem_Address];
                Mem_Valid_out <= 1'b1;
            end
        end
    end

    // Present a request and hold it until accepted; acc_cyc is the cycle number of the accept edge.
    task automatic send_req(input logic wr, input logic [4:0] a, input logic [31:0] d, output int acc_cyc);
        bit done;
        done = 1'b0;
        acc_cyc = -1;
        @(posedge CLK); #1;
        Req_Valid = 1'b1; Req_Write = wr; Req_Addr = a; Req_Wdata = d;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge CLK);
            if (Req_Ready) begin
                done = 1'b1;
                acc_cyc = cyc;
            end
        end
        @(posedge CLK); #1;
        Req_Valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL req_accept: Req_Ready never seen, required within 64 cycles");
        end
    endtask

    // Wait (bounded) for a response handshake; returns at the negedge before the accepting edge.
    task automatic get_rsp(output rsp_t got, output bit ok);
        ok = 1'b0;
        got = '0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge CLK);
            if (Rsp_Valid && Rsp_Ready) begin
                got = {Rsp_Write, Rsp_Rdata, Rsp_Err};
                ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({Req_Ready, Rsp_Valid, Rsp_Write, Rsp_Err, Mem_Wr_En, Mem_Rd_En, Mem_Address, Mem_Data_in, Rsp_Rdata} !== 73'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%0b rvalid=%0b wr=%0b rd=%0b addr=%0d din=%h rdata=%h, required all 0",
                     Req_Ready, Rsp_Valid, Mem_Wr_En, Mem_Rd_En, Mem_Address, Mem_Data_in, Rsp_Rdata);
        end
        @(negedge CLK); Rst_n = 1'b1;
        @(negedge CLK);
        checks++;
        if (Req_Ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: Req_Ready=%0b after release, required 1", Req_Ready);
        end
    endtask

    task automatic test_write();
        int acc;
        rsp_t e;
        exp_q.push_back('{wr: 1'b1, rdata: 32'd0, err: 1'b0});
        send_req(1'b1, 5'd5, 32'hDEADBEEF, acc);
        @(negedge CLK);
        checks++;
        if ({Mem_Wr_En, Mem_Rd_En, Mem_Address, Mem_Data_in, Rsp_Valid} !== {1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0}) begin
            errors++;
            $display("FAIL write_strobe: wr=%0b rd=%0b addr=%0d din=%h rvalid=%0b, required 1 0 5 deadbeef 0",
                     Mem_Wr_En, Mem_Rd_En, Mem_Address, Mem_Data_in, Rsp_Valid);
        end
        @(negedge CLK);
        e = exp_q.pop_front();
        checks++;
        if ({Mem_Wr_En, Rsp_Valid, Rsp_Write, Rsp_Rdata, Rsp_Err} !== {1'b0, 1'b1, e}) begin
            errors++;
            $display("FAIL write_rsp: wr_en=%0b rvalid=%0b write=%0b rdata=%h err=%0b, required 0 1 %0b %h %0b",
                     Mem_Wr_En, Rsp_Valid, Rsp_Write, Rsp_Rdata, Rsp_Err, e.wr, e.rdata, e.err);
        end
        exp_wr++;
        @(negedge CLK);
        checks++;
        if ({Req_Ready, Rsp_Valid} !== 2'b10) begin
            errors++;
            $display("FAIL write_idle: ready=%0b rvalid=%0b, required 1 0", Req_Ready, Rsp_Valid);
        end
    endtask

    task automatic test_read();
        int acc;
        rsp_t e;
        exp_q.push_back('{wr: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
        send_req(1'b0, 5'd5, 32'h0, acc);
        @(negedge CLK);
        checks++;
        if ({Mem_Rd_En, Mem_Wr_En, Mem_Address} !== {1'b1, 1'b0, 5'd5}) begin
            errors++;
            $display("FAIL read_strobe: rd=%0b wr=%0b addr=%0d, required 1 0 5", Mem_Rd_En, Mem_Wr_En, Mem_Address);
        end
        @(negedge CLK);
        checks++;
        if ({Mem_Rd_En, Rsp_Valid} !== 2'b00) begin
            errors++;
            $display("FAIL read_pulse: rd=%0b rvalid=%0b one cycle after accept, required 0 0", Mem_Rd_En, Rsp_Valid);
        end
        @(negedge CLK);
        e = exp_q.pop_front();
        checks++;
        if ({Rsp_Valid, Rsp_Write, Rsp_Rdata, Rsp_Err} !== {1'b1, e}) begin
            errors++;
            $display("FAIL read_rsp: rvalid=%0b write=%0b rdata=%h err=%0b, required 1 %0b %h %0b",
                     Rsp_Valid, Rsp_Write, Rsp_Rdata, Rsp_Err, e.wr, e.rdata, e.err);
        end
        exp_rd++;
    endtask

    task automatic test_boundary();
        logic        t_wr [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [4:0]  t_a  [5] = '{5'd0, 5'd31, 5'd0, 5'd31, 5'd5};
        logic [31:0] t_d  [5] = '{32'h1, 32'h8000_0000, 32'h1, 32'h8000_0000, 32'hDEADBEEF};
        int   acc;
        rsp_t e, got;
        bit   ok;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{wr: t_wr[i], rdata: (t_wr[i] ? 32'd0 : t_d[i]), err: 1'b0});
            send_req(t_wr[i], t_a[i], t_d[i], acc);
            get_rsp(got, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || got !== e) begin
                errors++;
                $display("FAIL boundary_%0d: ok=%0b write=%0b rdata=%h err=%0b, required write=%0b rdata=%h err=%0b",
                         i, ok, got.wr, got.rdata, got.err, e.wr, e.rdata, e.err);
            end
            if (t_wr[i]) exp_wr++; else exp_rd++;
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1;
        rsp_t e, got;
        bit ok;
        send_req(1'b1, 5'd10, 32'hA5A5_0010, a0);
        send_req(1'b1, 5'd11, 32'h5A5A_0011, a1);
        exp_wr += 2;
        checks++;
        if (a1 - a0 != 3) begin
            errors++;
            $display("FAIL b2b_write_spacing: %0d cycles, required 3", a1 - a0);
        end
        @(negedge CLK); @(negedge CLK); @(negedge CLK);
        send_req(1'b0, 5'd10, 32'h0, a0);
        send_req(1'b0, 5'd11, 32'h0, a1);
        exp_rd += 2;
        checks++;
        if (a1 - a0 != 4) begin
            errors++;
            $display("FAIL b2b_read_spacing: %0d cycles, required 4", a1 - a0);
        end
        @(negedge CLK); @(negedge CLK); @(negedge CLK); @(negedge CLK);
        exp_q.push_back('{wr: 1'b0, rdata: 32'h5A5A_0011, err: 1'b0});
        send_req(1'b0, 5'd11, 32'h0, a0);
        get_rsp(got, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL b2b_readback: ok=%0b rdata=%h err=%0b, required rdata=%h err=%0b", ok, got.rdata, got.err, e.rdata, e.err);
        end
        exp_rd++;
    endtask

    task automatic test_timeout();
        int acc, first;
        rsp_t e;
        stub = 1'b1;
        first = -1;
        exp_q.push_back('{wr: 1'b0, rdata: 32'd0, err: 1'b1});
        send_req(1'b0, 5'd0, 32'h0, acc);
        // Accept edge + 1 READ + 8 WAIT_RD edges, so Rsp_Valid first shows at the 10th negedge.
        for (int k = 1; k <= 30 && first < 0; k++) begin
            @(negedge CLK);
            if (Rsp_Valid) first = k;
        end
        e = exp_q.pop_front();
        checks++;
        if (first != 10 || {Rsp_Write, Rsp_Rdata, Rsp_Err} !== e) begin
            errors++;
            $display("FAIL timeout_rsp: seen at negedge %0d write=%0b rdata=%h err=%0b, required 10 %0b %h %0b",
                     first, Rsp_Write, Rsp_Rdata, Rsp_Err, e.wr, e.rdata, e.err);
        end
        exp_err++;
        @(negedge CLK);
        checks++;
        if ({Req_Ready, Rsp_Valid} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_idle: ready=%0b rvalid=%0b, required 1 0", Req_Ready, Rsp_Valid);
        end
        stub = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc;
        bit seen;
        rsp_t e, got;
        bit ok;
        seen = 1'b0;
        Rsp_Ready = 1'b0;
        exp_q.push_back('{wr: 1'b0, rdata: 32'h8000_0000, err: 1'b0});
        e = exp_q[0];
        send_req(1'b0, 5'd31, 32'h0, acc);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (Rsp_Valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_valid: Rsp_Valid not seen within 20 cycles, required");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if ({Rsp_Valid, Rsp_Write, Rsp_Rdata, Rsp_Err, Req_Ready} !== {1'b1, e, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold_%0d: rvalid=%0b write=%0b rdata=%h err=%0b ready=%0b, required 1 %0b %h %0b 0",
                         i, Rsp_Valid, Rsp_Write, Rsp_Rdata, Rsp_Err, Req_Ready, e.wr, e.rdata, e.err);
            end
        end
        @(posedge CLK); #1;
        Rsp_Ready = 1'b1;
        get_rsp(got, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL bp_rsp: ok=%0b rdata=%h err=%0b, required rdata=%h err=%0b", ok, got.rdata, got.err, e.rdata, e.err);
        end
        exp_rd++;
        @(negedge CLK);
        checks++;
        if ({Req_Ready, Rsp_Valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: ready=%0b rvalid=%0b after handshake, required 1 0", Req_Ready, Rsp_Valid);
        end
    endtask

    task automatic test_counters(input int w, input int r, input int er);
`ifdef MEM_INIT_TXN_COUNT_EN
        checks++;
        if (Wr_Count !== 16'(w) || Rd_Count !== 16'(r) || Err_Count !== 16'(er)) begin
            errors++;
            $display("FAIL counters: wr=%0d rd=%0d err=%0d, required %0d %0d %0d", Wr_Count, Rd_Count, Err_Count, w, r, er);
        end
`endif
        $display("info: transaction tally wr=%0d rd=%0d err=%0d", w, r, er);
    endtask

    task automatic test_reset_mid();
        int acc, stray;
        rsp_t e, got;
        bit ok;
        stub = 1'b1;
        send_req(1'b0, 5'd7, 32'h0, acc);
        @(negedge CLK); @(negedge CLK); @(negedge CLK);
        Rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({Mem_Rd_En, Rsp_Valid, Req_Ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid: rd=%0b rvalid=%0b ready=%0b, required 0 0 0", Mem_Rd_En, Rsp_Valid, Req_Ready);
        end
        @(negedge CLK); @(negedge CLK);
        Rst_n = 1'b1;
        stub = 1'b0;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (Rsp_Valid) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_no_rsp: Rsp_Valid seen %0d cycles after release, required 0", stray);
        end
        test_counters(0, 0, 0);
        exp_q.push_back('{wr: 1'b0, rdata: 32'd0, err: 1'b0});
        send_req(1'b0, 5'd5, 32'h0, acc);
        get_rsp(got, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL reset_readback: ok=%0b rdata=%h err=%0b, required rdata=%h err=%0b", ok, got.rdata, got.err, e.rdata, e.err);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_boundary();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        @(negedge CLK);
        test_counters(exp_wr, exp_rd, exp_err);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_initiator.md
Name: mem_access_initiator

Overview:
- Request-side controller for the 32x32 single-port memory. It accepts read/write commands on a valid/ready request channel and drives the memory's Wr_En/Rd_En/Address/Data_in pins.
- Read data is captured when the memory asserts Valid_out. Each command is returned as exactly one response on a valid/ready response channel.
- A watchdog covers a missing Valid_out.
- Sits between bus-side agents/testbench drivers and the memory instance.

Parameters:
- Data_Width, 32, width of data words.
- Address_Width, 5, width of memory address.
- Timeout_Cyc, 8, maximum cycles spent in WAIT_RD before an error response; legal range 2..255.

Ports:
- CLK  input  1  clock, rising edge.
- Rst_n  input  1  asynchronous reset, active-low.
- Req_Valid  input  1  request present.
- Req_Ready  output  1  initiator can accept a request.
- Req_Write  input  1  1 = write, 0 = read.
- Req_Addr  input  Address_Width  target address.
- Req_Wdata  input  Data_Width  write data.
- Rsp_Valid  output  1  response present.
- Rsp_Ready  input  1  consumer accepts the response.
- Rsp_Write  output  1  echo of the request type.
- Rsp_Rdata  output  Data_Width  read data; 0 for writes and errors.
- Rsp_Err  output  1  read timeout.
- Mem_Wr_En  output  1  to memory Wr_En.
- Mem_Rd_En  output  1  to memory Rd_En.
- Mem_Address  output  Address_Width  to memory Address.
- Mem_Data_in  output  Data_Width  to memory Data_in.
- Mem_Data_out  input  Data_Width  from memory Data_out.
- Mem_Valid_out  input  1  from memory Valid_out.

Behaviour:
- Reset: CLK and Rst_n, with Rst_n asynchronous active-low.
  - Asserting Rst_n forces state IDLE immediately.
  - All outputs go to 0 immediately, including Req_Ready, which returns to 1 only in IDLE after reset release.
  - An in-flight command is dropped; no response is produced.
- All outputs are registered; there are no combinational paths from input to output.
- FSM states are IDLE, WRITE, READ, WAIT_RD, RESP.
- IDLE:
  - Req_Ready=1.
  - On Req_Valid&Req_Ready at an edge: latch Req_Write, Req_Addr and Req_Wdata, then go to WRITE or READ.
- WRITE:
  - Mem_Wr_En=1 for exactly one cycle, with Mem_Address and Mem_Data_in set to the latched values.
  - Then go to RESP with Rsp_Write=1, Rsp_Err=0, Rsp_Rdata=0.
- READ:
  - Mem_Rd_En=1 for exactly one cycle, with Mem_Address set to the latched value.
  - Then go to WAIT_RD and clear the watchdog counter.
- WAIT_RD:
  - If Mem_Valid_out=1, capture Mem_Data_out into Rsp_Rdata, set Rsp_Err=0, go to RESP.
  - Else increment the counter. When the counter reaches Timeout_Cyc-1, go to RESP with Rsp_Err=1, Rsp_Rdata=0.
  - Mem_Valid_out is ignored in every state other than WAIT_RD.
- RESP:
  - Rsp_Valid=1.
  - Rsp_Write, Rsp_Rdata and Rsp_Err are held stable until Rsp_Valid&Rsp_Ready at an edge, then go to IDLE.
  - Rsp_Valid drops the cycle after the handshake.
- Latency, measured from the accept edge E0:
  - Write: Mem_Wr_En is high in cycle E0..E1, and Rsp_Valid is high from E1.
  - Read: Mem_Rd_En is high in E0..E1, the memory registers data at E1, capture happens at E2, and Rsp_Valid is high from E2.
- Invariants:
  - Mem_Wr_En and Mem_Rd_En are never both 1.
  - Each strobe is a single-cycle pulse per command.
  - Outside WRITE/READ, Mem_Address and Mem_Data_in hold their last values.
- One outstanding command at a time; Req_Ready=0 in all states except IDLE.
- Best-case throughput, with Rsp_Ready tied to 1: write takes 3 cycles per command, read takes 4.
- Addresses are used unmodified: the full 0..31 range, with no wrap logic.

Optional Feature:
- Macro: MEM_INIT_TXN_COUNT_EN.
- When defined, add three outputs: Wr_Count, Rd_Count and Err_Count, each 16 bits.
  - Each increments on the RESP handshake for its category.
  - A timed-out read increments Err_Count only.
  - Each counter saturates at 16'hFFFF.
  - All three reset to 0.
- When undefined, these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- After reset release, write addr 5 data 32'hDEADBEEF with Rsp_Ready=1.
  - Required: one-cycle Mem_Wr_En pulse with Mem_Address=5 and Mem_Data_in=32'hDEADBEEF.
  - Required: Rsp_Valid=1 with Rsp_Write=1 and Rsp_Err=0 the next cycle.
- Read addr 5 with the real memory connected.
  - Required: one-cycle Mem_Rd_En pulse.
  - Required: Rsp_Valid two edges after accept, with Rsp_Rdata=32'hDEADBEEF and Rsp_Err=0.
- Write addr 0 and addr 31 with data 32'h1 and 32'h8000_0000, then read both back.
  - Required: exact data returned; no cross-address corruption.
- Tie Mem_Valid_out=0 (memory stubbed) and issue a read with Timeout_Cyc=8.
  - Required: Rsp_Valid with Rsp_Err=1 and Rsp_Rdata=0 after 8 WAIT_RD cycles.
  - Required: the FSM returns to IDLE afterwards.
- Hold Rsp_Ready=0 for 5 cycles on a read response, then assert it.
  - Required: Rsp_* stable throughout and Req_Ready=0 throughout.
  - Required: Req_Ready=1 the cycle after the handshake.
- Assert Rst_n=0 while in WAIT_RD.
  - Required: Mem_Rd_En, Rsp_Valid and Req_Ready are 0 immediately.
  - Required: no response after release; a subsequent read of any address returns 0.
  - With MEM_INIT_TXN_COUNT_EN, all counters read 0 after reset.
